game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter ROWS_TO_WIN, default 12: frog row index that completes a level.
REQ-002 Parameter MAX_LEVEL, default 9: final level; completing it ends the game.
REQ-003 Parameter HOLD_CYCLES, default 24'd12_500_000: dwell time in DEAD and WIN before auto-advance.
REQ-004 Parameter FLASH_PERIOD, default 24'd8_388_608: menu blink half-period in cycles.
REQ-005 Ports SHALL be:
  clk  in  1  system clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  btn_up_tick  in  1  one-cycle up-press pulse
  btn_down_tick  in  1  one-cycle down-press pulse
  btn_any_tick  in  1  one-cycle any-key pulse
  collision  in  1  frog/hazard overlap, level-sensitive
  sound_ack  in  1  sound player accepted current request
  state  out  2  MENU=0, PLAYING=1, DEAD=2, WIN=3
  level  out  4  current level, 1..MAX_LEVEL
  score  out  10  points this game, 0..999
  hiscore  out  10  best score since reset, 0..999
  blink  out  1  menu subtitle visibility
  sound_req  out  1  sound request pending
  sound_type  out  2  UI_PRESS=0, NEXTLEVEL=1, CRASH=2, CELEBRATION=3

Function
REQ-006 All outputs SHALL be registered; every transition below takes effect on the cycle after its trigger is sampled.
REQ-007 MENU: btn_any_tick -> PLAYING; level=1, score=0, internal row cur_y=0, max_y=0; raise UI_PRESS.
REQ-008 PLAYING, priority order: collision -> DEAD with CRASH; else exactly one of up/down tick acts; both in same cycle are ignored.
REQ-009 Up tick: cur_y+1; if new cur_y > max_y then max_y=cur_y and score+1, saturating at 999 (no wrap).
REQ-010 Down tick: cur_y-1; at cur_y=0 no change.
REQ-011 cur_y reaching ROWS_TO_WIN -> WIN next cycle; sound NEXTLEVEL if level<MAX_LEVEL, else CELEBRATION.
REQ-012 DEAD/WIN: 24-bit hold counter cleared on entry, increments every cycle; at HOLD_CYCLES-1 leave state; buttons and collision ignored.
REQ-013 WIN exit: level<MAX_LEVEL -> PLAYING, level+1, cur_y=0, max_y=0, score kept; level==MAX_LEVEL -> MENU.
REQ-014 DEAD exit -> MENU; score holds its value until next game start.
REQ-015 hiscore SHALL update to score on any cycle where score>hiscore; never decreases except by reset.
REQ-016 blink: set to 1 on MENU entry; in MENU, counter toggles blink every FLASH_PERIOD cycles; outside MENU blink=0.
REQ-017 Sound handshake: raising an event sets sound_req=1 and sound_type; both held stable until sound_ack sampled with sound_req=1, then sound_req=0 next cycle.
REQ-018 New event while pending: replaces sound_type only if new code >= pending code, else dropped; ack and new event in same cycle -> sound_req stays 1 with new type.
REQ-019 sound_ack while sound_req=0 SHALL be ignored.

Reset
REQ-020 rst_n low SHALL immediately force state=MENU, level=1, score=0, hiscore=0, blink=1, sound_req=0, sound_type=0, cur_y=max_y=0, all counters 0, including mid-hold or mid-handshake.
REQ-021 First active edge after rst_n release SHALL behave as normal MENU operation.

Verification
REQ-022 Reset, btn_any_tick -> state=1, level=1, sound_req=1 type 0; ack -> sound_req=0 next cycle.
REQ-023 PLAYING: 3 up, 1 down, 1 up -> cur_y=3, score=3; up+down same cycle -> unchanged.
REQ-024 12 up ticks at level 1 -> state=3, type 1; after HOLD_CYCLES -> state=1, level=2, score=12.
REQ-025 Pending UI_PRESS unacked, collision -> state=2, sound_type=2; then NEXTLEVEL attempt blocked (type stays 2).
REQ-026 Game to score 7 then die -> hiscore=7; new game score 0, hiscore stays 7; rst_n pulse in DEAD -> all reset values.
REQ-027 Level MAX_LEVEL win -> type 3, then MENU, blink=1 toggling every FLASH_PERIOD.

Source files
------------

// File: rtl/game_ctrl.sv
// Game flow controller: menu/play/dead/win sequencing, scoring, hiscore, menu blink
// and a single-slot sound request handshake with priority replacement.
module game_ctrl #(
    parameter int unsigned ROWS_TO_WIN  = 12,
    parameter int unsigned MAX_LEVEL    = 9,
    parameter logic [23:0] HOLD_CYCLES  = 24'd12_500_000,
    parameter logic [23:0] FLASH_PERIOD = 24'd8_388_608
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_tick,
    input  logic       btn_down_tick,
    input  logic       btn_any_tick,
    input  logic       collision,
    input  logic       sound_ack,
    output logic [1:0] state,
    output logic [3:0] level,
    output logic [9:0] score,
    output logic [9:0] hiscore,
    output logic       blink,
    output logic       sound_req,
    output logic [1:0] sound_type
);

    localparam int unsigned YW = $clog2(ROWS_TO_WIN + 1);

    typedef enum logic [1:0] {
        StMenu    = 2'd0,
        StPlaying = 2'd1,
        StDead    = 2'd2,
        StWin     = 2'd3
    } state_e;

    localparam logic [1:0] SndUiPress     = 2'd0;
    localparam logic [1:0] SndNextLevel   = 2'd1;
    localparam logic [1:0] SndCrash       = 2'd2;
    localparam logic [1:0] SndCelebration = 2'd3;

    state_e          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic [9:0]      score_q, score_d;
    logic [9:0]      hiscore_q, hiscore_d;
    logic [YW-1:0]   cur_y_q, cur_y_d;
    logic [YW-1:0]   max_y_q, max_y_d;
    logic [23:0]     hold_q, hold_d;
    logic [23:0]     flash_q, flash_d;
    logic            blink_q, blink_d;
    logic            req_q, req_d;
    logic [1:0]      type_q, type_d;
    logic            ev_valid;
    logic [1:0]      ev_code;
    logic [YW-1:0]   up_y;

    assign up_y = cur_y_q + YW'(1);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        score_d  = score_q;
        cur_y_d  = cur_y_q;
        max_y_d  = max_y_q;
        hold_d   = 24'd0;
        ev_valid = 1'b0;
        ev_code  = SndUiPress;
        unique case (state_q)
            StMenu: begin
                if (btn_any_tick) begin
                    state_d  = StPlaying;
                    level_d  = 4'd1;
                    score_d  = 10'd0;
                    cur_y_d  = '0;
                    max_y_d  = '0;
                    ev_valid = 1'b1;
                    ev_code  = SndUiPress;
                end
            end
            StPlaying: begin
                if (collision) begin
                    state_d  = StDead;
                    ev_valid = 1'b1;
                    ev_code  = SndCrash;
                end else if (btn_up_tick && !btn_down_tick) begin
                    cur_y_d = up_y;
                    if (up_y > max_y_q) begin
                        max_y_d = up_y;
                        if (score_q != 10'd999) score_d = score_q + 10'd1;
                    end
                    if (up_y == YW'(ROWS_TO_WIN)) begin
                        state_d  = StWin;
                        ev_valid = 1'b1;
                        ev_code  = (level_q < 4'(MAX_LEVEL)) ? SndNextLevel : SndCelebration;
                    end
                end else if (btn_down_tick && !btn_up_tick && cur_y_q != '0) begin
                    cur_y_d = cur_y_q - YW'(1);
                end
            end
            StDead, StWin: begin
                if (hold_q == HOLD_CYCLES - 24'd1) begin
                    if (state_q == StWin && level_q < 4'(MAX_LEVEL)) begin
                        state_d = StPlaying;
                        level_d = level_q + 4'd1;
                        cur_y_d = '0;
                        max_y_d = '0;
                    end else begin
                        state_d = StMenu;
                    end
                end else begin
                    hold_d = hold_q + 24'd1;
                end
            end
            default: ;
        endcase
    end

    // Blink restarts visible on every menu entry and is forced low outside the menu.
    always_comb begin
        blink_d = 1'b0;
        flash_d = 24'd0;
        if (state_d == StMenu) begin
            if (state_q != StMenu) begin
                blink_d = 1'b1;
            end else if (flash_q == FLASH_PERIOD - 24'd1) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                flash_d = flash_q + 24'd1;
            end
        end
    end

    // An ack frees the slot in the same cycle, so a coincident event always wins it.
    always_comb begin
        req_d  = req_q;
        type_d = type_q;
        if (ev_valid) begin
            if (!req_q || sound_ack) begin
                req_d  = 1'b1;
                type_d = ev_code;
            end else if (ev_code >= type_q) begin
                type_d = ev_code;
            end
        end else if (sound_ack && req_q) begin
            req_d = 1'b0;
        end
    end

    assign hiscore_d = (score_q > hiscore_q) ? score_q : hiscore_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StMenu;
            level_q   <= 4'd1;
            score_q   <= 10'd0;
            hiscore_q <= 10'd0;
            cur_y_q   <= '0;
            max_y_q   <= '0;
            hold_q    <= 24'd0;
            flash_q   <= 24'd0;
            blink_q   <= 1'b1;
            req_q     <= 1'b0;
            type_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            cur_y_q   <= cur_y_d;
            max_y_q   <= max_y_d;
            hold_q    <= hold_d;
            flash_q   <= flash_d;
            blink_q   <= blink_d;
            req_q     <= req_d;
            type_q    <= type_d;
        end
    end

    assign state      = state_q;
    assign level      = level_q;
    assign score      = score_q;
    assign hiscore    = hiscore_q;
    assign blink      = blink_q;
    assign sound_req  = req_q;
    assign sound_type = type_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed table, hand-written corner sequences and random stimulus
// checked against a rule-level reference model.
module tb_game_ctrl;

    localparam int          ROWS  = 12;
    localparam int          MAXL  = 2;
    localparam logic [23:0] HOLD  = 24'd5;
    localparam logic [23:0] FLASH = 24'd6;

    logic       clk, rst_n;
    logic       up, dn, any, col, ack;
    logic [1:0] state;
    logic [3:0] level;
    logic [9:0] score, hiscore;
    logic       blink, sound_req;
    logic [1:0] sound_type;

    game_ctrl #(
        .ROWS_TO_WIN (ROWS),
        .MAX_LEVEL   (MAXL),
        .HOLD_CYCLES (HOLD),
        .FLASH_PERIOD(FLASH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up_tick  (up),
        .btn_down_tick(dn),
        .btn_any_tick (any),
        .collision    (col),
        .sound_ack    (ack),
        .state        (state),
        .level        (level),
        .score        (score),
        .hiscore      (hiscore),
        .blink        (blink),
        .sound_req    (sound_req),
        .sound_type   (sound_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: game phase, row progress, and ages since entering the current phase.
    int m_state, m_level, m_score, m_hi, m_y, m_maxy, m_age, m_req, m_type;

    function automatic int m_blink();
        return (m_state == 0) ? (((m_age / int'(FLASH)) % 2) == 0) : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 1; m_score = 0; m_hi = 0;
        m_y = 0; m_maxy = 0; m_age = 0; m_req = 0; m_type = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit a, input bit c, input bit k);
        int ns = m_state;
        int ev = -1;
        if (m_score > m_hi) m_hi = m_score;
        if (m_state == 0 && a) begin
            ns = 1; m_level = 1; m_score = 0; m_y = 0; m_maxy = 0; ev = 0;
        end else if (m_state == 1) begin
            if (c) begin
                ns = 2; ev = 2;
            end else if (u && !d) begin
                m_y++;
                if (m_y > m_maxy) begin
                    m_maxy = m_y;
                    m_score = (m_score >= 999) ? 999 : m_score + 1;
                end
                if (m_y == ROWS) begin
                    ns = 3; ev = (m_level < MAXL) ? 1 : 3;
                end
            end else if (d && !u && m_y > 0) begin
                m_y--;
            end
        end else if ((m_state == 2 || m_state == 3) && m_age == int'(HOLD) - 1) begin
            if (m_state == 3 && m_level < MAXL) begin
                ns = 1; m_level++; m_y = 0; m_maxy = 0;
            end else begin
                ns = 0;
            end
        end
        if (ev >= 0) begin
            if (!m_req || k) begin
                m_req = 1; m_type = ev;
            end else if (ev >= m_type) begin
                m_type = ev;
            end
        end else if (k && m_req) begin
            m_req = 0;
        end
        m_age = (ns != m_state) ? 0 : m_age + 1;
        m_state = ns;
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        checks++;
        if (int'(state) != m_state || int'(level) != m_level || int'(score) != m_score ||
            int'(hiscore) != m_hi || int'(blink) != m_blink() || int'(sound_req) != m_req ||
            int'(sound_type) != m_type) begin
            failures++;
            $display("FAIL %s: got st=%0d lv=%0d sc=%0d hi=%0d bl=%0d rq=%0d ty=%0d expected st=%0d lv=%0d sc=%0d hi=%0d bl=%0d rq=%0d ty=%0d",
                     name, state, level, score, hiscore, blink, sound_req, sound_type,
                     m_state, m_level, m_score, m_hi, m_blink(), m_req, m_type);
        end
    endtask

    task automatic cycle(input bit u, input bit d, input bit a, input bit c, input bit k,
                         input string name);
        @(negedge clk);
        up = u; dn = d; any = a; col = c; ack = k;
        model_step(u, d, a, c, k);
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic wait_state(input int target, input int budget, input bit a, input bit c,
                              input string name);
        for (int i = 0; i < budget && int'(state) != target; i++) cycle(0, 0, a, c, 0, name);
        expect_eq({name, "_reached"}, int'(state), target);
    endtask

    typedef struct {
        bit u, d, a, c, k;
        int st, sc, rq, ty;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst_n = 1'b0; up = 0; dn = 0; any = 0; col = 0; ack = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_eq("rst_state", int'(state), 0);
        expect_eq("rst_level", int'(level), 1);
        expect_eq("rst_blink", int'(blink), 1);
        expect_eq("rst_req", int'(sound_req), 0);
        check_model("rst_all");

        //           u  d  a  c  k  st sc rq ty
        tbl[0] = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
        tbl[1] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 1, 2, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0, 1, 3, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 0, 1, 3, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 0, 1, 3, 0, 0};
        tbl[7] = '{1, 1, 0, 0, 0, 1, 3, 0, 0};
        tbl[8] = '{1, 0, 0, 0, 0, 1, 4, 0, 0};
        tbl[9] = '{0, 0, 0, 0, 1, 1, 4, 0, 0};
        foreach (tbl[i]) begin
            cycle(tbl[i].u, tbl[i].d, tbl[i].a, tbl[i].c, tbl[i].k, $sformatf("tbl%0d", i));
            expect_eq($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            expect_eq($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
            expect_eq($sformatf("tbl%0d_req", i), int'(sound_req), tbl[i].rq);
            expect_eq($sformatf("tbl%0d_type", i), int'(sound_type), tbl[i].ty);
        end

        // Reach score 7, crash, inputs ignored while dead.
        repeat (3) cycle(1, 0, 0, 0, 0, "climb7");
        expect_eq("score7", int'(score), 7);
        cycle(0, 0, 0, 1, 0, "crash");
        expect_eq("crash_state", int'(state), 2);
        expect_eq("crash_type", int'(sound_type), 2);
        cycle(1, 0, 1, 1, 0, "dead_ignore");
        expect_eq("dead_ignore_state", int'(state), 2);
        wait_state(0, 20, 0, 0, "dead_exit");
        expect_eq("hiscore7", int'(hiscore), 7);
        expect_eq("menu_blink", int'(blink), 1);

        // Lower-priority UI_PRESS must not displace pending CRASH.
        cycle(0, 0, 1, 0, 0, "restart");
        expect_eq("restart_score", int'(score), 0);
        expect_eq("drop_type", int'(sound_type), 2);
        expect_eq("drop_req", int'(sound_req), 1);
        expect_eq("restart_hiscore", int'(hiscore), 7);
        cycle(0, 0, 0, 0, 1, "ack_crash");
        expect_eq("ack_req", int'(sound_req), 0);

        repeat (ROWS) cycle(1, 0, 0, 0, 0, "climb_l1");
        expect_eq("win1_state", int'(state), 3);
        expect_eq("win1_type", int'(sound_type), 1);
        wait_state(1, 20, 0, 0, "win1_exit");
        expect_eq("lvl2", int'(level), 2);
        expect_eq("lvl2_score", int'(score), 12);

        repeat (ROWS) cycle(1, 0, 0, 0, 0, "climb_l2");
        expect_eq("win2_state", int'(state), 3);
        expect_eq("win2_type", int'(sound_type), 3);
        wait_state(0, 20, 0, 0, "win2_exit");
        expect_eq("final_blink_on", int'(blink), 1);
        repeat (int'(FLASH) - 1) cycle(0, 0, 0, 0, 0, "blink_hold");
        expect_eq("blink_still_on", int'(blink), 1);
        cycle(0, 0, 0, 0, 0, "blink_tog");
        expect_eq("blink_off", int'(blink), 0);
        repeat (int'(FLASH)) cycle(0, 0, 0, 0, 0, "blink_tog2");
        expect_eq("blink_on_again", int'(blink), 1);
        expect_eq("hiscore24", int'(hiscore), 24);

        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(9, 0) < 4, $urandom_range(9, 0) < 2, $urandom_range(9, 0) < 1,
                  $urandom_range(49, 0) < 1, $urandom_range(9, 0) < 3, "random");
        end

        // Asynchronous reset in the middle of a DEAD hold.
        wait_state(2, 40, 1, 1, "to_dead");
        cycle(0, 0, 0, 0, 0, "mid_hold");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        expect_eq("async_rst_state", int'(state), 0);
        expect_eq("async_rst_score", int'(score), 0);
        expect_eq("async_rst_hiscore", int'(hiscore), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 0, 0, "post_rst_start");
        expect_eq("post_rst_state", int'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
